// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester handshakes and the data-memory bus that
// dmem_arbiter sits between.
//
// Handshake (both requesters): a requester raises ReqN with WeN/AddrN/WdataN
// and holds all four stable until it sees GntN high. GntN is high for exactly
// one cycle, which is the cycle the memory access is performed. A requester
// may keep ReqN high through the GntN cycle to queue another access. For a
// read, RvalidN pulses for one cycle right after GntN, and RdataN holds the
// data until the next read by the same requester.
//
// Signals:
//   Req0/We0/Addr0/Wdata0   requester 0 request (core load/store path)
//   Gnt0/Rvalid0/Rdata0     requester 0 grant and read return
//   Req1/We1/Addr1/Wdata1   requester 1 request (loader / debug port)
//   Gnt1/Rvalid1/Rdata1     requester 1 grant and read return
//   Lock0/Lock1             bus lock requests (only with DMEM_ARB_LOCK_EN)
//   MemWriteEn/MemToReg/MemAddr/MemWdata  drive the single-port data memory
//   MemRdata                data memory read port
//   dbg_state_o             arbiter FSM state (0 = IDLE, 1 = ACCESS)
//
// Modports: slave = the arbiter, master = requesters plus memory.
// Optional macro: DMEM_ARB_LOCK_EN adds Lock0/Lock1.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              Req0;
    logic              We0;
    logic [ADDR_W-1:0] Addr0;
    logic [DATA_W-1:0] Wdata0;
    logic              Gnt0;
    logic              Rvalid0;
    logic [DATA_W-1:0] Rdata0;

    logic              Req1;
    logic              We1;
    logic [ADDR_W-1:0] Addr1;
    logic [DATA_W-1:0] Wdata1;
    logic              Gnt1;
    logic              Rvalid1;
    logic [DATA_W-1:0] Rdata1;

`ifdef DMEM_ARB_LOCK_EN
    logic              Lock0;
    logic              Lock1;
`endif

    logic              MemWriteEn;
    logic              MemToReg;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [DATA_W-1:0] MemRdata;

    logic              dbg_state_o;

    modport slave (
        input  Req0, We0, Addr0, Wdata0,
        input  Req1, We1, Addr1, Wdata1,
`ifdef DMEM_ARB_LOCK_EN
        input  Lock0, Lock1,
`endif
        input  MemRdata,
        output Gnt0, Rvalid0, Rdata0,
        output Gnt1, Rvalid1, Rdata1,
        output MemWriteEn, MemToReg, MemAddr, MemWdata,
        output dbg_state_o
    );

    modport master (
        output Req0, We0, Addr0, Wdata0,
        output Req1, We1, Addr1, Wdata1,
`ifdef DMEM_ARB_LOCK_EN
        output Lock0, Lock1,
`endif
        output MemRdata,
        input  Gnt0, Rvalid0, Rdata0,
        input  Gnt1, Rvalid1, Rdata1,
        input  MemWriteEn, MemToReg, MemAddr, MemWdata,
        input  dbg_state_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester round-robin arbiter and sequencer for the 256x8 single-port
// data memory. One access at a time: an IDLE cycle samples the requests and
// captures the winner's command, the following ACCESS cycle drives the
// memory and pulses the winner's grant. Read data is registered at the end of
// ACCESS into the owner's Rdata register together with a one-cycle Rvalid.
//
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous, active-high reset
//   bus    dmem_arbiter_if.slave (requester handshakes + memory bus)
//
// Optional macro: DMEM_ARB_LOCK_EN. When defined, a winner that requests
// Lock keeps exclusive access until it is granted an access with Lock low.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef DMEM_ARB_LOCK_EN
    logic              locked_q, locked_d;
    logic              lock_owner_q, lock_owner_d;
`endif

    logic              elig0, elig1;
    logic              winner;
    logic              gnt0, gnt1;
    logic              mem_we, mem_to_reg;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;   // requester 0 wins the first tie
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q     <= 1'b0;
            lock_owner_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
`ifdef DMEM_ARB_LOCK_EN
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        elig0 = bus.Req0;
        elig1 = bus.Req1;
`ifdef DMEM_ARB_LOCK_EN
        locked_d     = locked_q;
        lock_owner_d = lock_owner_q;
        // While locked, the other requester is simply invisible to arbitration.
        if (locked_q) begin
            elig0 = bus.Req0 & ~lock_owner_q;
            elig1 = bus.Req1 &  lock_owner_q;
        end
`endif
        // A tie goes to whoever did not win last; otherwise the lone requester.
        winner = (elig0 && elig1) ? ~last_gnt_q : elig1;

        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    state_d    = ST_ACCESS;
                    owner_d    = winner;
                    last_gnt_d = winner;
                    we_d       = winner ? bus.We1    : bus.We0;
                    addr_d     = winner ? bus.Addr1  : bus.Addr0;
                    wdata_d    = winner ? bus.Wdata1 : bus.Wdata0;
`ifdef DMEM_ARB_LOCK_EN
                    // A beat with Lock low is the final beat of a locked burst.
                    locked_d     = winner ? bus.Lock1 : bus.Lock0;
                    lock_owner_d = winner;
`endif
                end
            end
            ST_ACCESS: begin
                state_d    = ST_IDLE;
                gnt0       = ~owner_q;
                gnt1       = owner_q;
                mem_addr   = addr_q;
                mem_we     = we_q;
                mem_to_reg = ~we_q;
                mem_wdata  = we_q ? wdata_q : '0;
                if (!we_q) begin
                    if (owner_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = bus.MemRdata;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = bus.MemRdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory controls decode straight from the state register so an
    // asynchronous reset removes MemWriteEn without waiting for a clock.
    assign bus.Gnt0        = gnt0;
    assign bus.Gnt1        = gnt1;
    assign bus.Rvalid0     = rvalid0_q;
    assign bus.Rvalid1     = rvalid1_q;
    assign bus.Rdata0      = rdata0_q;
    assign bus.Rdata1      = rdata1_q;
    assign bus.MemWriteEn  = mem_we;
    assign bus.MemToReg    = mem_to_reg;
    assign bus.MemAddr     = mem_addr;
    assign bus.MemWdata    = mem_wdata;
    assign bus.dbg_state_o = (state_q == ST_ACCESS);
endmodule
